// File: rtl/dsram_store_buf.sv
// Store buffer and port arbiter for the single data-SRAM port behind the D-TLB stage.
// Stores are absorbed into an in-order FIFO and drained when the port is free;
// loads take the port first unless they alias a buffered store by word address.
//
// Handshakes: a pipeline request transfers when pipe_en & ~stallreq & ~ext_stall
// (only stores are captured; loads are simply re-presented until they transfer).
// An SRAM access transfers when sram_en & sram_ready; a head write that transfers
// pops the FIFO.
module dsram_store_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic                     pipe_wen,
    input  logic [DW/8-1:0]          pipe_sel,
    input  logic [AW-1:0]            pipe_addr,
    input  logic [DW-1:0]            pipe_wdata,
    input  logic                     ext_stall,
    output logic                     stallreq,
    output logic                     sram_en,
    output logic                     sram_wen,
    output logic [DW/8-1:0]          sram_sel,
    output logic [AW-1:0]            sram_addr,
    output logic [DW-1:0]            sram_wdata,
    input  logic                     sram_ready,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = DW / 8;

    logic [AW-1:0] addr_q [DEPTH];
    logic [SW-1:0] sel_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;

    logic is_load;
    logic is_store;
    logic full;
    logic alias_hit;
    logic head_wr;
    logic pop;
    logic fire;
    logic push;

    assign is_load   = pipe_en & ~pipe_wen;
    assign is_store  = pipe_en & pipe_wen;
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign buf_empty = (count_q == '0);
    assign buf_count = count_q;

    // Alias detection: a load matches any occupied slot on word address; byte enables are ignored.
    always_comb begin
        alias_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head_q} < count_q) &&
                (addr_q[i][AW-1:2] == pipe_addr[AW-1:2])) begin
                alias_hit = 1'b1;
            end
        end
        alias_hit = alias_hit & is_load;
    end

    // Port arbitration: non-aliasing load first, otherwise drain the head entry.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 1'b0;
        sram_sel   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        head_wr    = 1'b0;
        if (is_load && !alias_hit) begin
            sram_en   = 1'b1;
            sram_sel  = pipe_sel;
            sram_addr = pipe_addr;
        end else if (!buf_empty) begin
            sram_en    = 1'b1;
            sram_wen   = 1'b1;
            sram_sel   = sel_q[head_q];
            sram_addr  = addr_q[head_q];
            sram_wdata = data_q[head_q];
            head_wr    = 1'b1;
        end
    end

    // Stall generation: loads wait for the port or for aliasing stores to drain; stores wait for space.
    always_comb begin
        pop      = head_wr & sram_ready;
        stallreq = 1'b0;
        if (is_load) begin
            stallreq = alias_hit | ~sram_ready;
        end else if (is_store) begin
            stallreq = full & ~pop;
        end
        fire = pipe_en & ~stallreq & ~ext_stall;
        push = fire & pipe_wen;
    end

    // FIFO pointers and occupancy; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= pipe_addr;
            sel_q[tail_q]  <= pipe_sel;
            data_q[tail_q] <= pipe_wdata;
        end
    end

endmodule

// File: tb/tb_dsram_store_buf.sv
// Bench for dsram_store_buf: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model and a write-order scoreboard.
module tb_dsram_store_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pipe_en = 1'b0;
  logic             pipe_wen = 1'b0;
  logic [SW-1:0]    pipe_sel = '0;
  logic [AW-1:0]    pipe_addr = '0;
  logic [DW-1:0]    pipe_wdata = '0;
  logic             ext_stall = 1'b0;
  logic             stallreq;
  logic             sram_en;
  logic             sram_wen;
  logic [SW-1:0]    sram_sel;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic             sram_ready = 1'b0;
  logic [$clog2(DEPTH):0] buf_count;
  logic             buf_empty;

  int vectors = 0;
  int miscompares = 0;

  // {addr, sel, data}: addr at [67:36], sel at [35:32], data at [31:0]
  logic [67:0] exp_q[$];
  logic [67:0] model_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  dsram_store_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_en    (pipe_en),
    .pipe_wen   (pipe_wen),
    .pipe_sel   (pipe_sel),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .ext_stall  (ext_stall),
    .stallreq   (stallreq),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_sel   (sram_sel),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .buf_count  (buf_count),
    .buf_empty  (buf_empty)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every accepted SRAM write must be the oldest outstanding store
  initial begin
    forever begin
      @(negedge clk);
      if (sram_en && sram_wen && sram_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL drain_unexpected: got write to %0h expected no write at %0t", sram_addr, $time);
        end else begin
          chk("drain_order", 72'({sram_addr, sram_sel, sram_wdata}), 72'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver: apply one cycle of inputs, check against the model, then advance the model
  task automatic cycle(input logic en, input logic wen, input logic [SW-1:0] sel,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic ext, input logic rdy, output logic fired);
    logic is_load, is_store, al, pop, stall;
    logic p_en, p_wen;
    logic [SW-1:0] p_sel;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    int n;
    @(posedge clk); #1;
    pipe_en = en; pipe_wen = wen; pipe_sel = sel; pipe_addr = addr;
    pipe_wdata = wd; ext_stall = ext; sram_ready = rdy;
    @(negedge clk); #1;
    n = model_q.size();
    is_load = en & ~wen;
    is_store = en & wen;
    al = 1'b0;
    foreach (model_q[i]) if (is_load && model_q[i][67:38] == addr[31:2]) al = 1'b1;
    p_en = 1'b0; p_wen = 1'b0; p_sel = '0; p_addr = '0; p_wd = '0;
    if (is_load && !al) begin
      p_en = 1'b1; p_sel = sel; p_addr = addr;
    end else if (n > 0) begin
      p_en = 1'b1; p_wen = 1'b1;
      p_sel = model_q[0][35:32]; p_addr = model_q[0][67:36]; p_wd = model_q[0][31:0];
    end
    pop = p_en & p_wen & rdy;
    if (is_load) stall = al ? 1'b1 : ~rdy;
    else if (is_store) stall = (n == DEPTH) && !pop;
    else stall = 1'b0;
    chk("stallreq", 72'(stallreq), 72'(stall));
    chk("sram_port", 72'({sram_en, sram_wen, sram_sel, sram_addr, sram_wdata}),
        72'({p_en, p_wen, p_sel, p_addr, p_wd}));
    chk("buf_count", 72'(buf_count), 72'(n));
    chk("buf_empty", 72'(buf_empty), 72'(n == 0));
    fired = en & ~stall & ~ext;
    if (pop) void'(model_q.pop_front());
    if (fired && wen) begin
      model_q.push_back({addr, sel, wd});
      exp_q.push_back({addr, sel, wd});
    end
  endtask

  task automatic idle(input int cycles, input logic rdy);
    logic f;
    for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, rdy, f);
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; pipe_en = 1'b0; pipe_wen = 1'b0; ext_stall = 1'b0; sram_ready = rdy;
    @(negedge clk); #1;
    model_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic f;
    int k;
    logic en, wen, ext, rdy;
    logic [SW-1:0] sel;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1, 1'b0);

    // three back-to-back stores drain in order starting the cycle after the first
    cycle(1'b1, 1'b1, 4'hF, 32'h100, 32'hA0A0_0001, 1'b0, 1'b1, f);
    cycle(1'b1, 1'b1, 4'h3, 32'h104, 32'hA0A0_0002, 1'b0, 1'b1, f);
    cycle(1'b1, 1'b1, 4'hC, 32'h108, 32'hA0A0_0003, 1'b0, 1'b1, f);
    idle(4, 1'b1);

    // fill to DEPTH with the port blocked; fifth store waits for the first pop
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 4'hF, 32'h10 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, f);
    cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'hB000_0004, 1'b0, 1'b0, f);
    chk("full_not_accepted", 72'(f), 72'(0));
    cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'hB000_0004, 1'b0, 1'b1, f);
    chk("full_pop_accepted", 72'(f), 72'(1));
    idle(1, 1'b0);
    idle(6, 1'b1);

    // non-aliasing load bypasses a buffered store
    cycle(1'b1, 1'b1, 4'hF, 32'h200, 32'hC000_0200, 1'b0, 1'b0, f);
    cycle(1'b0, 1'b0, 4'h1, 32'h300, 32'h0, 1'b0, 1'b1, f);
    cycle(1'b1, 1'b0, 4'h1, 32'h300, 32'h0, 1'b0, 1'b1, f);
    idle(1, 1'b0);
    cycle(1'b1, 1'b1, 4'hF, 32'h200, 32'hC000_0201, 1'b0, 1'b0, f);
    cycle(1'b1, 1'b0, 4'h1, 32'h300, 32'h0, 1'b0, 1'b1, f);
    idle(3, 1'b1);

    // aliasing load waits for both older stores to drain
    cycle(1'b1, 1'b1, 4'hF, 32'h204, 32'hD000_0204, 1'b0, 1'b0, f);
    cycle(1'b1, 1'b1, 4'hF, 32'h208, 32'hD000_0208, 1'b0, 1'b0, f);
    k = 0;
    f = 1'b0;
    while (!f && k < 20) begin
      cycle(1'b1, 1'b0, 4'h8, 32'h20B, 32'h0, 1'b0, 1'b1, f);
      k++;
    end
    chk("alias_wait_cycles", 72'(k), 72'(3));
    idle(2, 1'b1);

    // store held by ext_stall is captured exactly once
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'hF, 32'h400, 32'hE000_0400, 1'b1, 1'b0, f);
    cycle(1'b1, 1'b1, 4'hF, 32'h400, 32'hE000_0400, 1'b0, 1'b0, f);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // reset while mid-drain discards the remaining entries
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 4'hF, 32'h500 + 32'(i * 4), 32'hF000_0000 + 32'(i), 1'b0, 1'b0, f);
    idle(1, 1'b1);
    do_reset(1'b1);
    idle(5, 1'b1);

    // randomized traffic over a small address window so aliases are frequent
    en = 1'b0; wen = 1'b0; sel = '0; a = '0; d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!en || f) begin
        en  = ($urandom_range(0, 3) != 0);
        wen = ($urandom_range(0, 1) != 0);
        a   = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        sel = SW'($urandom_range(1, 15));
        d   = $urandom;
      end
      ext = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cycle(en, wen, sel, a, d, ext, rdy, f);
    end

    k = 0;
    while (model_q.size() != 0 && k < 50) begin
      idle(1, 1'b1);
      k++;
    end
    idle(2, 1'b1);
    chk("final_drain", 72'(exp_q.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsram_store_buf.md
Name: dsram_store_buf

Overview:
- Controller and arbiter for the single data-SRAM port driven by the D-TLB stage.
- Stores from the pipeline are absorbed into a small in-order store buffer and drained to the SRAM when the port is free.
- Loads take the port with priority; a load that aliases a buffered store is held off until the buffer drains.
- Sits between the D-TLB stage SRAM bus outputs and the data-SRAM/dcache port; generates a stall request to the pipeline controller.

Parameters:
- DEPTH, 4, store-buffer entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width; byte-select width is DW/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_en  in  1  pipeline data-SRAM request valid
- pipe_wen  in  1  1 = store, 0 = load
- pipe_sel  in  DW/8  byte enables
- pipe_addr  in  AW  physical address
- pipe_wdata  in  DW  store data
- ext_stall  in  1  stage held by another stall source this cycle; request will be re-presented
- stallreq  out  1  request to stall the D-TLB stage and all earlier stages
- sram_en  out  1  data-SRAM enable
- sram_wen  out  1  data-SRAM write
- sram_sel  out  DW/8  data-SRAM byte enables
- sram_addr  out  AW  data-SRAM address
- sram_wdata  out  DW  data-SRAM write data
- sram_ready  in  1  port accepted this cycle's access (dcache not busy)
- buf_count  out  log2(DEPTH)+1  valid entries
- buf_empty  out  1  buf_count == 0

Behaviour:
- Storage: circular FIFO of {addr, sel, wdata}, with head and tail pointers wrapping mod DEPTH and count 0..DEPTH.
- Reset: pointers and count = 0 and contents discarded, including entries mid-drain.
  - With pipe_en=0 and the buffer empty: sram_en=0, stallreq=0, buf_empty=1, buf_count=0.
- fire = pipe_en & ~stallreq & ~ext_stall.
- alias = pipe_en & ~pipe_wen & any valid entry with addr[AW-1:2] == pipe_addr[AW-1:2].
  - Match is on word address only; pipe_sel is ignored (conservative).
- Port arbitration (combinational, every cycle):
  - Load, no alias: drive the load on the port (sram_en=1, wen=0, sel/addr from the pipe, wdata=0).
    - stallreq = ~sram_ready.
    - A load under ext_stall is reissued next cycle (idempotent).
  - Load with alias: drive the head entry (sram_en=1, wen=1); stallreq=1.
  - Otherwise, buffer non-empty: drive the head entry as a write.
  - Otherwise: sram_en=0, with wen/sel/addr/wdata all 0.
- Store handling:
  - stallreq=1 if count==DEPTH and no pop occurs this cycle; otherwise 0.
  - Enqueue only on fire.
  - Stores never go directly to the SRAM; the earliest SRAM write is the cycle after acceptance.
- Pop: head advances when a head write is driven and sram_ready=1.
- Simultaneous push and pop is legal at any count, including full. count is unchanged; both pointers advance.
- Ordering: buffered writes drain strictly FIFO. Loads may bypass buffered stores only when there is no alias.
- stallreq is purely combinational from the current inputs and FIFO state; no registered outputs except buf_count.
- Load data return is outside this block; the SRAM rdata timing is unchanged.
- Latencies:
  - Load with no alias: 0 cycles added.
  - Load with alias: stalled until the aliasing entry and all older entries have popped.

Test Plan:
- Reset, then 3 stores to 0x100/0x104/0x108 on consecutive cycles with sram_ready=1 → stallreq=0 throughout; writes appear in order 0x100, 0x104, 0x108 starting 1 cycle after the first store; buf_empty=1 after the last pop.
- 5 stores back-to-back with sram_ready=0 → 4 accepted, buf_count=4, stallreq=1 on the 5th. Raise sram_ready → 5th accepted in the first pop cycle, count stays 4.
- Buffer holds a store to 0x200; load 0x300 → load drives the port the same cycle, stallreq=0, store drains afterwards.
- Buffer holds stores to 0x204 then 0x208; load 0x20B → stallreq=1 for 2 cycles while both drain; load issued on the 3rd cycle.
- Store presented with ext_stall=1 for 3 cycles, then 0 → exactly one entry enqueued (buf_count=1).
- Buffer at count=3 mid-drain; assert rst → next cycle buf_count=0, sram_en=0, stallreq=0; no further writes issued.
